gun_shot_sequencer: RTL and testbench

- Sequences a light-gun shot across video frames: on a shot pulse, blanks the screen for a black frame, then draws the target as a white box for a target frame.
- Counts photodetector samples during each phase and issues registered one-cycle hit/miss pulses.
- When no gun is connected, mouse shots resolve immediately.
- Sits between the input governor (shot/connect/photodetector signals) and the draw pipeline (blank/target overlay enables) and the game FSM (hit/miss).

---
 rtl/ctl_pkg.sv | 35 +++
 rtl/gun_shot_sequencer_det_counter.sv | 56 +++++
 rtl/gun_shot_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_gun_shot_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctl_pkg.sv
// ----------------------------------------------------------------------------
// ctl_pkg
// Shared definitions for the light-gun shot sequencer: the sequencer state
// encoding, default tuning constants and a small helper for sizing counters.
// No ports; imported by gun_shot_sequencer and det_counter.
// ----------------------------------------------------------------------------
package ctl_pkg;

   // Sequencer states. IDLE is the only state in which a new shot is accepted.
   typedef enum logic [2:0] {
      IDLE,
      WAIT_FRAME,
      BLACK,
      TARGET,
      RESULT,
      RESOLVE_MOUSE,
      COOLDOWN
   } shot_state_t;

   // Minimum number of photodetector-high cycles in a phase to call it lit.
   localparam int DET_MIN_DEF = 4;

   // Frames after a result during which new shots are ignored.
   localparam int COOLDOWN_FRAMES_DEF = 8;

   // Largest of three frame counts, used to size the shared frame counter.
   function automatic int maxOf3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/gun_shot_sequencer_det_counter.sv
// ----------------------------------------------------------------------------
// det_counter
// Saturating counter of photodetector-high cycles with a synchronous clear and
// a count enable. Reports whether the count has reached THRESH.
//
// Ports:
//   clk_i          clock
//   rst_ni         synchronous active-low reset
//   clear_i        clears the count (wins over enable)
//   enable_i       counts one cycle when high
//   atThreshold_o  count >= THRESH (from the registered count)
// ----------------------------------------------------------------------------
module det_counter
   import ctl_pkg::*;
#(
   parameter int CNT_W  = 12,
   parameter int THRESH = DET_MIN_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic atThreshold_o
);

   localparam logic [CNT_W-1:0] SatValue    = '1;
   localparam logic [CNT_W-1:0] ThreshValue = CNT_W'(THRESH);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clearing takes priority, and counting stops at all-ones so a
   // long exposure to light can never wrap back to a small value.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && (count_q != SatValue)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Threshold compare on the registered count, so the sample taken in the
   // cycle a phase closes is not part of that phase's decision.
   assign atThreshold_o = (count_q >= ThreshValue);

endmodule

// File: rtl/gun_shot_sequencer.sv
// ----------------------------------------------------------------------------
// gun_shot_sequencer
// Sequences a light-gun shot over video frames. A shot with the gun attached
// blanks the screen for BLACK_FRAMES frames, then paints the target white for
// TARGET_FRAMES frames while counting photodetector-high cycles in each phase.
// Light during the target frames and darkness during the black frames is a
// hit; anything else (including a lamp that is bright all along) is a miss.
// Without a gun, a mouse shot resolves immediately from mouse_on_target.
//
// Ports:
//   clk                pixel clock
//   rst                synchronous active-low reset
//   frame_tick         one-cycle pulse at the start of each frame
//   gun_is_connected   gun presence level
//   shot_fired         shot request, rising edge detected here
//   gun_photodetector  1 = light seen (already synchronised)
//   mouse_on_target    mouse cursor is inside the target box
//   blank_screen       registered, draw pipeline forces black
//   draw_target        registered, draw pipeline paints target white
//   hit / miss         registered one-cycle result pulses
//   busy               a shot sequence is in progress
// ----------------------------------------------------------------------------
module gun_shot_sequencer
   import ctl_pkg::*;
#(
   parameter int BLACK_FRAMES    = 1,
   parameter int TARGET_FRAMES   = 1,
   parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF,
   parameter int DET_MIN         = DET_MIN_DEF,
   parameter int CNT_W           = 12
) (
   input  logic clk,
   input  logic rst,
   input  logic frame_tick,
   input  logic gun_is_connected,
   input  logic shot_fired,
   input  logic gun_photodetector,
   input  logic mouse_on_target,
   output logic blank_screen,
   output logic draw_target,
   output logic hit,
   output logic miss,
   output logic busy
);

   localparam int FrameMax = maxOf3(BLACK_FRAMES, TARGET_FRAMES, COOLDOWN_FRAMES);
   localparam int FCW      = $clog2(FrameMax) + 1;

   localparam logic [FCW-1:0] BlackCount  = FCW'(BLACK_FRAMES);
   localparam logic [FCW-1:0] TargetCount = FCW'(TARGET_FRAMES);
   localparam logic [FCW-1:0] CoolCount   = FCW'(COOLDOWN_FRAMES);

   shot_state_t    state_q;
   shot_state_t    state_d;
   logic [FCW-1:0] frameCnt_q;
   logic [FCW-1:0] frameCnt_d;
   logic [FCW-1:0] frameNext;
   logic           shotFired_q;
   logic           shotEdge;
   logic           blankScreen_q;
   logic           blankScreen_d;
   logic           drawTarget_q;
   logic           drawTarget_d;
   logic           hit_q;
   logic           hit_d;
   logic           miss_q;
   logic           miss_d;
   logic           blackLit_q;
   logic           blackLit_d;
   logic           targetLit_q;
   logic           targetLit_d;
   logic           inPhase;
   logic           detClear;
   logic           detEnable;
   logic           detLit;

   // A shot is a rising edge of shot_fired, so a held trigger fires once.
   assign shotEdge = shot_fired & ~shotFired_q;

   // Photodetector counting is only meaningful while the black or target
   // overlay is on screen.
   assign inPhase = (state_q == BLACK) || (state_q == TARGET);

   // The detector counter restarts at every state change so each phase gets
   // its own count; outside the phases it is held at zero.
   assign detClear  = (state_d != state_q) || !inPhase;
   assign detEnable = inPhase & gun_photodetector;

   det_counter #(
      .CNT_W  (CNT_W),
      .THRESH (DET_MIN)
   ) u_detCounter (
      .clk_i         (clk),
      .rst_ni        (rst),
      .clear_i       (detClear),
      .enable_i      (detEnable),
      .atThreshold_o (detLit)
   );

   // Next-state and next-output logic. Losing the gun while the overlay
   // sequence is pending or on screen abandons the shot without a result.
   // Phase changes only happen on frame_tick so the overlay stays frame
   // aligned; the light verdict of each phase is latched as it closes.
   always_comb begin
      state_d     = state_q;
      frameNext   = frameCnt_q + FCW'(1);
      frameCnt_d  = frameCnt_q;
      hit_d       = 1'b0;
      miss_d      = 1'b0;
      blackLit_d  = blackLit_q;
      targetLit_d = targetLit_q;

      case (state_q)
         IDLE: begin
            if (shotEdge) begin
               state_d = gun_is_connected ? WAIT_FRAME : RESOLVE_MOUSE;
            end
         end
         RESOLVE_MOUSE: begin
            hit_d   = mouse_on_target;
            miss_d  = ~mouse_on_target;
            state_d = COOLDOWN;
         end
         WAIT_FRAME: begin
            if (!gun_is_connected) begin
               state_d = IDLE;
            end else if (frame_tick) begin
               state_d = BLACK;
            end
         end
         BLACK: begin
            if (!gun_is_connected) begin
               state_d = IDLE;
            end else if (frame_tick && (frameNext >= BlackCount)) begin
               state_d    = TARGET;
               blackLit_d = detLit;
            end
         end
         TARGET: begin
            if (!gun_is_connected) begin
               state_d = IDLE;
            end else if (frame_tick && (frameNext >= TargetCount)) begin
               state_d     = RESULT;
               targetLit_d = detLit;
            end
         end
         RESULT: begin
            hit_d   = targetLit_q & ~blackLit_q;
            miss_d  = ~(targetLit_q & ~blackLit_q);
            state_d = COOLDOWN;
         end
         COOLDOWN: begin
            if (COOLDOWN_FRAMES == 0) begin
               state_d = IDLE;
            end else if (frame_tick && (frameNext >= CoolCount)) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_d != state_q) begin
         frameCnt_d = '0;
      end else if (frame_tick &&
                   ((state_q == BLACK) || (state_q == TARGET) || (state_q == COOLDOWN))) begin
         frameCnt_d = frameNext;
      end

      blankScreen_d = (state_d == BLACK) || (state_d == TARGET);
      drawTarget_d  = (state_d == TARGET);
   end

   // State, counters and registered outputs. Reset wins at any point in a
   // sequence and drops every output on the same edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= IDLE;
         frameCnt_q    <= '0;
         shotFired_q   <= 1'b0;
         blankScreen_q <= 1'b0;
         drawTarget_q  <= 1'b0;
         hit_q         <= 1'b0;
         miss_q        <= 1'b0;
         blackLit_q    <= 1'b0;
         targetLit_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         frameCnt_q    <= frameCnt_d;
         shotFired_q   <= shot_fired;
         blankScreen_q <= blankScreen_d;
         drawTarget_q  <= drawTarget_d;
         hit_q         <= hit_d;
         miss_q        <= miss_d;
         blackLit_q    <= blackLit_d;
         targetLit_q   <= targetLit_d;
      end
   end

   assign blank_screen = blankScreen_q;
   assign draw_target  = drawTarget_q;
   assign hit          = hit_q;
   assign miss         = miss_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_gun_shot_sequencer.sv
// ----------------------------------------------------------------------------
// tb_gun_shot_sequencer
// Each scenario is a timeline of input vectors. The expected outputs for the
// whole timeline are derived from event positions: the accepted shot edge,
// the frame ticks that open and close each phase, the light counts inside
// each phase, any disconnect or reset, and the cooldown ticks.
// ----------------------------------------------------------------------------
module tb_gun_shot_sequencer;

   localparam int N               = 260;
   localparam int BLACK_FRAMES    = 1;
   localparam int TARGET_FRAMES   = 1;
   localparam int COOLDOWN_FRAMES = 8;
   localparam int DET_MIN         = 4;
   localparam int NONE            = N + 1000;

   logic clk               = 1'b0;
   logic rst               = 1'b0;
   logic frame_tick        = 1'b0;
   logic gun_is_connected  = 1'b0;
   logic shot_fired        = 1'b0;
   logic gun_photodetector = 1'b0;
   logic mouse_on_target   = 1'b0;
   logic blank_screen;
   logic draw_target;
   logic hit;
   logic miss;
   logic busy;

   int compared   = 0;
   int mismatched = 0;

   bit         tickA  [N];
   bit         shotA  [N];
   bit         detA   [N];
   bit         connA  [N];
   bit         mouseA [N];
   bit         rstA   [N];
   logic [4:0] expA   [N];

   int    shotAt;
   int    resetAt;
   int    t1;
   int    t2;
   int    t3;
   string tag;

   gun_shot_sequencer #(
      .BLACK_FRAMES    (BLACK_FRAMES),
      .TARGET_FRAMES   (TARGET_FRAMES),
      .COOLDOWN_FRAMES (COOLDOWN_FRAMES),
      .DET_MIN         (DET_MIN),
      .CNT_W           (12)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .frame_tick        (frame_tick),
      .gun_is_connected  (gun_is_connected),
      .shot_fired        (shot_fired),
      .gun_photodetector (gun_photodetector),
      .mouse_on_target   (mouse_on_target),
      .blank_screen      (blank_screen),
      .draw_target       (draw_target),
      .hit               (hit),
      .miss              (miss),
      .busy              (busy)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Index of the n-th frame tick at or after cycle 'from'.
   function automatic int nthTick(input int from, input int n);
      int seen;
      seen = 0;
      for (int i = from; i < N; i++) begin
         if (i >= 0 && tickA[i]) begin
            seen++;
            if (seen == n) return i;
         end
      end
      return NONE;
   endfunction

   // Fresh timeline: reset for three cycles, gun attached, periodic ticks.
   task automatic newScenario(input int per);
      int ph;
      ph      = $urandom_range(0, per - 1);
      resetAt = -1;
      for (int i = 0; i < N; i++) begin
         tickA[i]  = (i >= ph) && (((i - ph) % per) == 0);
         shotA[i]  = 1'b0;
         detA[i]   = 1'b0;
         connA[i]  = 1'b1;
         mouseA[i] = 1'b0;
         rstA[i]   = (i >= 3);
      end
   endtask

   task automatic addShot(input int at, input int len);
      for (int i = at; i < at + len && i < N; i++) shotA[i] = 1'b1;
   endtask

   task automatic setConn(input int lo, input int hi, input bit v);
      for (int i = lo; i <= hi && i < N; i++) connA[i] = v;
   endtask

   task automatic setMouse(input bit v);
      for (int i = 0; i < N; i++) mouseA[i] = v;
   endtask

   // Black phase is on screen for cycles t1+1..t2, target for t2+1..t3.
   task automatic findPhases();
      t1 = nthTick(shotAt + 1, 1);
      t2 = nthTick(t1 + 1, BLACK_FRAMES);
      t3 = nthTick(t2 + 1, TARGET_FRAMES);
   endtask

   // Light 'cnt' random non-tick cycles inside [lo, hi].
   task automatic placeDet(input int lo, input int hi, input int cnt);
      int q[$];
      int k;
      for (int i = lo; i <= hi && i < N; i++) begin
         if (!tickA[i]) q.push_back(i);
      end
      for (int j = 0; j < cnt && q.size() > 0; j++) begin
         k = $urandom_range(0, q.size() - 1);
         detA[q[k]] = 1'b1;
         q.delete(k);
      end
   endtask

   // Expected {blank, draw, hit, miss, busy} after each clock edge.
   task automatic computeExpected();
      int  blankLo, blankHi, drawLo, resCyc, endBusy, abortAt;
      int  blackCnt, targetCnt;
      bit  isHit;
      blankLo = NONE; blankHi = -1; drawLo = NONE; resCyc = -1; isHit = 1'b0;
      if (!connA[shotAt]) begin
         resCyc  = shotAt + 2;
         isHit   = mouseA[shotAt + 1];
         endBusy = nthTick(resCyc, COOLDOWN_FRAMES);
      end else begin
         findPhases();
         abortAt = -1;
         for (int i = shotAt + 1; i <= t3 && i < N; i++) begin
            if (!connA[i] && abortAt < 0) abortAt = i;
         end
         blankLo = t1 + 1;
         drawLo  = t2 + 1;
         if (abortAt >= 0) begin
            blankHi = abortAt;
            endBusy = abortAt;
         end else begin
            blankHi   = t3;
            blackCnt  = 0;
            targetCnt = 0;
            for (int i = t1 + 1; i < t2 && i < N; i++) blackCnt  += int'(detA[i]);
            for (int i = t2 + 1; i < t3 && i < N; i++) targetCnt += int'(detA[i]);
            isHit   = (targetCnt >= DET_MIN) && (blackCnt < DET_MIN);
            resCyc  = t3 + 2;
            endBusy = nthTick(resCyc, COOLDOWN_FRAMES);
         end
      end
      for (int k = 0; k < N; k++) begin
         expA[k][4] = (k >= blankLo) && (k <= blankHi);
         expA[k][3] = (k >= drawLo) && (k <= blankHi);
         expA[k][2] = (k == resCyc) && isHit;
         expA[k][1] = (k == resCyc) && !isHit;
         expA[k][0] = (k >= shotAt + 1) && (k <= endBusy);
         if (k <= 3) expA[k] = '0;
         if (resetAt >= 0 && k >= resetAt + 1) expA[k] = '0;
      end
   endtask

   task automatic checkOutput(input int i);
      logic [4:0] obs;
      obs = {blank_screen, draw_target, hit, miss, busy};
      compared++;
      assert (obs === expA[i]) else begin
         mismatched++;
         $error("[TB] FAIL %s cycle %0d: observed blank/draw/hit/miss/busy=%05b expected %05b",
                tag, i, obs, expA[i]);
      end
   endtask

   // Replay the timeline: check what the last edge produced, then drive the
   // inputs that the next edge will sample.
   task automatic applyStimulus();
      for (int i = 0; i < N; i++) begin
         @(posedge clk);
         #1;
         checkOutput(i);
         rst               = rstA[i];
         frame_tick        = tickA[i];
         shot_fired        = shotA[i];
         gun_photodetector = detA[i];
         gun_is_connected  = connA[i];
         mouse_on_target   = mouseA[i];
      end
   endtask

   task automatic runScenario(input string name);
      tag = name;
      $display("[TB] scenario %s", name);
      computeExpected();
      applyStimulus();
   endtask

   initial begin
      // Mouse hit: shot edge sampled with no gun attached.
      newScenario(14);
      setConn(0, N - 1, 1'b0);
      setMouse(1'b1);
      shotAt = 10;
      addShot(shotAt, 1);
      runScenario("mouse_hit");

      // Mouse miss with a long held trigger.
      newScenario($urandom_range(10, 16));
      setConn(0, N - 1, 1'b0);
      shotAt = 7;
      addShot(shotAt, 4);
      runScenario("mouse_miss");

      // Gun hit: dark black frame, ten lit cycles in the target frame.
      newScenario($urandom_range(11, 16));
      shotAt = 8;
      addShot(shotAt, 2);
      findPhases();
      placeDet(t2 + 1, t3 - 1, 10);
      runScenario("gun_hit");

      // Lamp: light in every cycle of both phases.
      newScenario($urandom_range(10, 16));
      shotAt = 6;
      addShot(shotAt, 1);
      findPhases();
      placeDet(t1 + 1, t2 - 1, 99);
      placeDet(t2 + 1, t3 - 1, 99);
      runScenario("lamp_cheat");

      // Marginal light: one short of the threshold, then exactly on it.
      newScenario($urandom_range(10, 16));
      shotAt = 9;
      addShot(shotAt, 1);
      findPhases();
      placeDet(t2 + 1, t3 - 1, DET_MIN - 1);
      runScenario("marginal_3");

      newScenario($urandom_range(10, 16));
      shotAt = 9;
      addShot(shotAt, 1);
      findPhases();
      placeDet(t2 + 1, t3 - 1, DET_MIN);
      runScenario("marginal_4");

      // Black phase exactly at threshold turns a lit target into a miss.
      newScenario($urandom_range(10, 16));
      shotAt = 11;
      addShot(shotAt, 1);
      findPhases();
      placeDet(t1 + 1, t2 - 1, DET_MIN);
      placeDet(t2 + 1, t3 - 1, 8);
      runScenario("black_at_min");

      // Extra shot edges in TARGET and in COOLDOWN are dropped.
      newScenario($urandom_range(10, 16));
      shotAt = 5;
      addShot(shotAt, 1);
      findPhases();
      placeDet(t2 + 1, t3 - 1, 6);
      addShot(t2 + 3, 2);
      addShot(t3 + 10, 1);
      runScenario("busy_shots");

      // Shot edge on a tick cycle: black starts at the following tick.
      newScenario($urandom_range(10, 16));
      shotAt = nthTick(6, 1);
      addShot(shotAt, 1);
      findPhases();
      placeDet(t2 + 1, t3 - 1, 5);
      runScenario("shot_on_tick");

      // Gun unplugged in the middle of the black frame.
      newScenario($urandom_range(10, 16));
      shotAt = 7;
      addShot(shotAt, 1);
      findPhases();
      setConn(t1 + 3, N - 1, 1'b0);
      runScenario("abort_black");

      // Reset during the target frame.
      newScenario($urandom_range(10, 16));
      shotAt = 9;
      addShot(shotAt, 1);
      findPhases();
      placeDet(t2 + 1, t3 - 1, 6);
      resetAt = t2 + 4;
      rstA[resetAt]     = 1'b0;
      rstA[resetAt + 1] = 1'b0;
      runScenario("reset_target");

      // Randomised shots over both paths and a spread of light counts.
      for (int r = 0; r < 5; r++) begin
         newScenario($urandom_range(10, 16));
         shotAt = $urandom_range(5, 20);
         addShot(shotAt, $urandom_range(1, 3));
         if ($urandom_range(0, 3) == 0) begin
            setConn(0, N - 1, 1'b0);
            setMouse(1'($urandom_range(0, 1)));
         end else begin
            findPhases();
            placeDet(t1 + 1, t2 - 1, $urandom_range(0, 5));
            placeDet(t2 + 1, t3 - 1, $urandom_range(0, 9));
         end
         runScenario($sformatf("random_%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
